// File: rtl/max7219_pkg.sv
// Shared constants and types for the MAX7219 refresh scheduler.
package max7219_pkg;

  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCAN      = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  localparam int unsigned INIT_LEN = 5;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FRAME, ST_CFG} state_t;
  typedef enum logic {PH_ISSUE, PH_WAITD} phase_t;
  typedef enum logic [1:0] {FMT_INIT, FMT_DIGIT, FMT_INTEN} fmt_mode_t;

endpackage

// File: rtl/max7219_word_fmt.sv
// Combinational packer: builds the 16-bit {4'h0, addr, data} driver word.
module max7219_word_fmt
  import max7219_pkg::*;
#(
  parameter logic [2:0] SCAN_LIMIT     = 3'd5,
  parameter logic [3:0] INTENSITY_INIT = 4'h8
) (
  input  fmt_mode_t   i_mode,
  input  logic [2:0]  i_idx,
  input  logic [7:0]  i_data,
  output logic [15:0] o_word
);

  logic [3:0] w_digit_addr;

  assign w_digit_addr = ADDR_DIGIT0 + {1'b0, i_idx};

  always_comb begin
    o_word = '0;
    case (i_mode)
      FMT_INIT: begin
        case (i_idx)
          3'd0:    o_word = {4'h0, ADDR_SHUTDOWN, 8'h01};
          3'd1:    o_word = {4'h0, ADDR_DECODE, 8'hFF};
          3'd2:    o_word = {4'h0, ADDR_SCAN, 5'b00000, SCAN_LIMIT};
          3'd3:    o_word = {4'h0, ADDR_INTENSITY, 4'h0, INTENSITY_INIT};
          3'd4:    o_word = {4'h0, ADDR_TEST, 8'h00};
          default: o_word = '0;
        endcase
      end
      FMT_DIGIT: o_word = {4'h0, w_digit_addr, i_data};
      FMT_INTEN: o_word = {4'h0, ADDR_INTENSITY, i_data};
      default:   o_word = '0;
    endcase
  end

endmodule

// File: rtl/max7219_refresh_scheduler.sv
// Sequences init, per-tick digit refresh frames and intensity updates to the SPI master.
module max7219_refresh_scheduler
  import max7219_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 6,
  parameter logic [2:0]  SCAN_LIMIT     = 3'd5,
  parameter logic [3:0]  INTENSITY_INIT = 4'h8
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    tick,
  input  logic                    display_ena,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    intensity_req,
  input  logic [3:0]              intensity_val,
  output logic                    intensity_ack,
  output logic                    word_valid,
  output logic [15:0]             word_data,
  input  logic                    word_accept,
  input  logic                    word_done,
  output logic                    init_done,
  output logic                    busy,
  output logic                    overrun
);

  localparam logic [2:0] LAST_INIT  = 3'(INIT_LEN - 1);
  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

  state_t                  r_state, w_nxt_state;
  phase_t                  r_phase, w_nxt_phase;
  logic [2:0]              r_idx, w_nxt_idx, w_idx_inc, w_fmt_idx;
  logic                    r_valid, r_init_done, r_busy, r_ack, r_ovr, r_pend;
  logic [15:0]             r_word;
  logic [4*NUM_DIGITS-1:0] r_snap_digits;
  logic [NUM_DIGITS-1:0]   r_snap_dp;
  logic                    w_load, w_clr_valid, w_snap, w_init_fin, w_ack, w_ovr;
  logic                    w_pend_nxt, w_tick;
  fmt_mode_t               w_fmt_mode;
  logic [7:0]              w_fmt_data;
  logic [15:0]             w_word;

  assign w_tick    = tick & display_ena;
  assign w_idx_inc = r_idx + 3'd1;

  max7219_word_fmt #(
    .SCAN_LIMIT    (SCAN_LIMIT),
    .INTENSITY_INIT(INTENSITY_INIT)
  ) u_fmt (
    .i_mode(w_fmt_mode),
    .i_idx (w_fmt_idx),
    .i_data(w_fmt_data),
    .o_word(w_word)
  );

  // Next word is formatted from next-state values so it registers on the same edge it is chosen.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_phase = r_phase;
    w_nxt_idx   = r_idx;
    w_load      = 1'b0;
    w_clr_valid = 1'b0;
    w_snap      = 1'b0;
    w_init_fin  = 1'b0;
    w_ack       = 1'b0;
    w_ovr       = 1'b0;
    w_pend_nxt  = r_pend;
    w_fmt_mode  = FMT_INIT;
    w_fmt_idx   = r_idx;
    w_fmt_data  = '0;
    case (r_state)
      ST_IDLE: begin
        if (intensity_req) begin
          w_nxt_state = ST_CFG;
          w_nxt_phase = PH_ISSUE;
          w_load      = 1'b1;
          w_fmt_mode  = FMT_INTEN;
          w_fmt_data  = {4'h0, intensity_val};
          if (w_tick) begin
            if (r_pend) w_ovr = 1'b1;
            else        w_pend_nxt = 1'b1;
          end
        end else if (r_pend || w_tick) begin
          w_nxt_state = ST_FRAME;
          w_nxt_phase = PH_ISSUE;
          w_nxt_idx   = '0;
          w_load      = 1'b1;
          w_snap      = 1'b1;
          w_pend_nxt  = 1'b0;
          w_fmt_mode  = FMT_DIGIT;
          w_fmt_idx   = '0;
          w_fmt_data  = {dp_mask[0], 3'b000, digits[3:0]};
        end
      end
      default: begin
        if (r_state != ST_INIT && w_tick) begin
          if (r_pend) w_ovr = 1'b1;
          else        w_pend_nxt = 1'b1;
        end
        if (r_phase == PH_ISSUE) begin
          if (!r_valid) begin
            w_load = 1'b1;
          end else if (word_accept) begin
            w_clr_valid = 1'b1;
            w_nxt_phase = PH_WAITD;
            w_ack       = (r_state == ST_CFG);
          end
        end else if (word_done) begin
          case (r_state)
            ST_INIT: begin
              if (r_idx == LAST_INIT) begin
                w_nxt_state = ST_IDLE;
                w_init_fin  = 1'b1;
              end else begin
                w_nxt_idx   = w_idx_inc;
                w_nxt_phase = PH_ISSUE;
                w_load      = 1'b1;
                w_fmt_idx   = w_idx_inc;
              end
            end
            ST_FRAME: begin
              if (r_idx == LAST_DIGIT) begin
                w_nxt_state = ST_IDLE;
              end else begin
                w_nxt_idx   = w_idx_inc;
                w_nxt_phase = PH_ISSUE;
                w_load      = 1'b1;
                w_fmt_mode  = FMT_DIGIT;
                w_fmt_idx   = w_idx_inc;
                w_fmt_data  = {r_snap_dp[w_idx_inc], 3'b000, r_snap_digits[4*w_idx_inc +: 4]};
              end
            end
            default: w_nxt_state = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state       <= ST_INIT;
      r_phase       <= PH_ISSUE;
      r_idx         <= '0;
      r_valid       <= 1'b0;
      r_word        <= '0;
      r_init_done   <= 1'b0;
      r_busy        <= 1'b1;
      r_ack         <= 1'b0;
      r_ovr         <= 1'b0;
      r_pend        <= 1'b0;
      r_snap_digits <= '0;
      r_snap_dp     <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_phase <= w_nxt_phase;
      r_idx   <= w_nxt_idx;
      if (w_load) begin
        r_valid <= 1'b1;
        r_word  <= w_word;
      end else if (w_clr_valid) begin
        r_valid <= 1'b0;
      end
      if (w_snap) begin
        r_snap_digits <= digits;
        r_snap_dp     <= dp_mask;
      end
      if (w_init_fin) r_init_done <= 1'b1;
      r_busy <= (w_nxt_state != ST_IDLE);
      r_ack  <= w_ack;
      r_ovr  <= w_ovr;
      r_pend <= w_pend_nxt;
    end
  end

  assign word_valid    = r_valid;
  assign word_data     = r_word;
  assign init_done     = r_init_done;
  assign busy          = r_busy;
  assign intensity_ack = r_ack;
  assign overrun       = r_ovr;

endmodule

// File: tb/tb_max7219_refresh_scheduler.sv
// Self-checking bench: SPI-master stand-in plus word-list reference model of the scheduler.
module tb_max7219_refresh_scheduler;

  localparam int ND = 6;

  logic          clk = 1'b0;
  logic          res, tick, display_ena, intensity_req, word_accept, word_done;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] dp_mask;
  logic [3:0]    intensity_val;
  logic          intensity_ack, word_valid, init_done, busy, overrun;
  logic [15:0]   word_data;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] cap_q[$];
  int          done_cnt = 0;
  bit          acc_rand = 1'b0;
  int          ack_cnt = 0;
  int          ovr_cnt = 0;
  int          valid_cyc = 0;

  logic [15:0] INIT_EXP [5] = '{16'h0C01, 16'h09FF, 16'h0B05, 16'h0A08, 16'h0F00};

  always #5 clk = ~clk;

  max7219_refresh_scheduler #(
    .NUM_DIGITS    (ND),
    .SCAN_LIMIT    (3'd5),
    .INTENSITY_INIT(4'h8)
  ) dut (
    .clk          (clk),
    .res          (res),
    .tick         (tick),
    .display_ena  (display_ena),
    .digits       (digits),
    .dp_mask      (dp_mask),
    .intensity_req(intensity_req),
    .intensity_val(intensity_val),
    .intensity_ack(intensity_ack),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_accept  (word_accept),
    .word_done    (word_done),
    .init_done    (init_done),
    .busy         (busy),
    .overrun      (overrun)
  );

  // SPI master stand-in: records each transfer and answers with word_done 34 cycles later.
  initial begin
    word_accept = 1'b1;
    word_done   = 1'b0;
    forever begin
      @(negedge clk);
      word_done = 1'b0;
      if (res) begin
        done_cnt = 0;
      end else begin
        if (done_cnt > 0) begin
          done_cnt--;
          if (done_cnt == 0) word_done = 1'b1;
        end
        word_accept = acc_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (word_valid && word_accept) begin
          cap_q.push_back(word_data);
          done_cnt = 34;
        end
        if (intensity_ack) ack_cnt++;
        if (overrun) ovr_cnt++;
        if (word_valid) valid_cyc++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: digit i goes to register i+1, DP in bit 7, BCD in the low nibble.
  function automatic logic [15:0] digit_word(input int i, input logic [23:0] d, input logic [5:0] dp);
    int bcd;
    int v;
    bcd = int'((d >> (4 * i)) & 24'hF);
    v = (i + 1) * 256 + (dp[i] ? 128 : 0) + bcd;
    return 16'(v);
  endfunction

  function automatic logic [23:0] rand_bcd();
    logic [23:0] r;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic pulse_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget, input string tag);
    int k = 0;
    while (cap_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (cap_q.size() < n) begin
      n_err++;
      $display("FAIL %s_words_timeout got %0d words want %0d", tag, cap_q.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    @(negedge clk);
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle_timeout busy=%b want 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    res = 1'b1; tick = 1'b0; display_ena = 1'b1; intensity_req = 1'b0;
    intensity_val = 4'h0; digits = '0; dp_mask = '0; acc_rand = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL reset_word_valid got %b want 0", word_valid); end
    n_vec++; if (word_data !== 16'h0000) begin n_err++; $display("FAIL reset_word_data got %h want 0000", word_data); end
    n_vec++; if (init_done !== 1'b0) begin n_err++; $display("FAIL reset_init_done got %b want 0", init_done); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy got %b want 1", busy); end
    n_vec++; if (intensity_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b want 0", intensity_ack); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got %b want 0", overrun); end
    cap_q.delete();
    #1 res = 1'b0;
    @(negedge clk);
    n_vec++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL first_valid got %b want 1", word_valid); end
    n_vec++; if (word_data !== 16'h0C01) begin n_err++; $display("FAIL first_word got %h want 0c01", word_data); end
  endtask

  task automatic test_init();
    ovr_cnt = 0;
    repeat (40) @(negedge clk);
    pulse_tick();
    repeat (60) @(negedge clk);
    pulse_tick();
    wait_words(5, 400, "init");
    wait_idle(100, "init");
    n_vec++; if (cap_q.size() != 5) begin n_err++; $display("FAIL init_count got %0d want 5", cap_q.size()); end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (i >= cap_q.size() || cap_q[i] !== INIT_EXP[i]) begin
        n_err++;
        $display("FAIL init_word%0d got %h want %h", i, (i < cap_q.size()) ? cap_q[i] : 16'hxxxx, INIT_EXP[i]);
      end
    end
    n_vec++; if (init_done !== 1'b1) begin n_err++; $display("FAIL init_done got %b want 1", init_done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL init_busy got %b want 0", busy); end
    repeat (60) @(negedge clk);
    n_vec++; if (cap_q.size() != 5) begin n_err++; $display("FAIL init_tick_ignored got %0d words want 5", cap_q.size()); end
    n_vec++; if (ovr_cnt != 0) begin n_err++; $display("FAIL init_overrun got %0d want 0", ovr_cnt); end
  endtask

  task automatic test_frame();
    logic [15:0] exp_w [6] = '{16'h0104, 16'h0203, 16'h0382, 16'h0401, 16'h0589, 16'h0605};
    cap_q.delete();
    digits = 24'h591234;
    dp_mask = 6'b010100;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    n_vec++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL frame_latency_valid got %b want 1", word_valid); end
    n_vec++; if (word_data !== 16'h0104) begin n_err++; $display("FAIL frame_latency_word got %h want 0104", word_data); end
    repeat (45) @(negedge clk);
    digits = rand_bcd();
    dp_mask = 6'($urandom);
    repeat (60) @(negedge clk);
    digits = rand_bcd();
    dp_mask = ~dp_mask;
    wait_words(6, 400, "frame");
    wait_idle(100, "frame");
    n_vec++; if (cap_q.size() != 6) begin n_err++; $display("FAIL frame_count got %0d want 6", cap_q.size()); end
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (i >= cap_q.size() || cap_q[i] !== exp_w[i]) begin
        n_err++;
        $display("FAIL frame_word%0d got %h want %h", i, (i < cap_q.size()) ? cap_q[i] : 16'hxxxx, exp_w[i]);
      end
    end
  endtask

  task automatic test_random_frames();
    acc_rand = 1'b1;
    for (int it = 0; it < 4; it++) begin
      logic [23:0] d;
      logic [5:0]  p;
      d = rand_bcd();
      p = 6'($urandom);
      digits = d;
      dp_mask = p;
      cap_q.delete();
      pulse_tick();
      repeat ($urandom_range(1, 60)) @(negedge clk);
      digits = rand_bcd();
      dp_mask = 6'($urandom);
      wait_words(6, 800, "rand_frame");
      wait_idle(300, "rand_frame");
      n_vec++; if (cap_q.size() != 6) begin n_err++; $display("FAIL rand_frame_count got %0d want 6", cap_q.size()); end
      for (int i = 0; i < 6; i++) begin
        n_vec++;
        if (i >= cap_q.size() || cap_q[i] !== digit_word(i, d, p)) begin
          n_err++;
          $display("FAIL rand_frame%0d_word%0d got %h want %h", it, i, (i < cap_q.size()) ? cap_q[i] : 16'hxxxx, digit_word(i, d, p));
        end
      end
    end
    acc_rand = 1'b0;
  endtask

  task automatic test_display_off();
    logic [3:0] v;
    int k;
    display_ena = 1'b0;
    cap_q.delete();
    valid_cyc = 0;
    ovr_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      pulse_tick();
      repeat (98) @(negedge clk);
    end
    n_vec++; if (cap_q.size() != 0) begin n_err++; $display("FAIL dispoff_words got %0d want 0", cap_q.size()); end
    n_vec++; if (valid_cyc != 0) begin n_err++; $display("FAIL dispoff_valid got %0d cycles want 0", valid_cyc); end
    n_vec++; if (ovr_cnt != 0) begin n_err++; $display("FAIL dispoff_overrun got %0d want 0", ovr_cnt); end
    v = 4'($urandom);
    ack_cnt = 0;
    @(negedge clk);
    intensity_req = 1'b1;
    intensity_val = v;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    k = 0;
    while (!intensity_ack && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_vec++; if (intensity_ack !== 1'b1) begin n_err++; $display("FAIL dispoff_ack got %b want 1", intensity_ack); end
    intensity_req = 1'b0;
    intensity_val = ~v;
    wait_idle(100, "dispoff_cfg");
    repeat (50) @(negedge clk);
    n_vec++; if (cap_q.size() != 1) begin n_err++; $display("FAIL dispoff_cfg_count got %0d want 1", cap_q.size()); end
    n_vec++;
    if (cap_q.size() < 1 || cap_q[0] !== (16'h0A00 + 16'(v))) begin
      n_err++;
      $display("FAIL dispoff_cfg_word got %h want %h", (cap_q.size() > 0) ? cap_q[0] : 16'hxxxx, 16'h0A00 + 16'(v));
    end
    n_vec++; if (ack_cnt != 1) begin n_err++; $display("FAIL dispoff_ack_count got %0d want 1", ack_cnt); end
    display_ena = 1'b1;
  endtask

  task automatic test_overrun();
    logic [23:0] d;
    logic [5:0]  p;
    d = rand_bcd();
    p = 6'($urandom);
    digits = d;
    dp_mask = p;
    cap_q.delete();
    ovr_cnt = 0;
    pulse_tick();
    repeat (30) @(negedge clk);
    pulse_tick();
    repeat (30) @(negedge clk);
    pulse_tick();
    wait_words(12, 1000, "overrun");
    wait_idle(200, "overrun");
    repeat (100) @(negedge clk);
    n_vec++; if (cap_q.size() != 12) begin n_err++; $display("FAIL overrun_count got %0d want 12", cap_q.size()); end
    for (int i = 0; i < 12; i++) begin
      n_vec++;
      if (i >= cap_q.size() || cap_q[i] !== digit_word(i % 6, d, p)) begin
        n_err++;
        $display("FAIL overrun_word%0d got %h want %h", i, (i < cap_q.size()) ? cap_q[i] : 16'hxxxx, digit_word(i % 6, d, p));
      end
    end
    n_vec++; if (ovr_cnt != 1) begin n_err++; $display("FAIL overrun_pulses got %0d want 1", ovr_cnt); end
  endtask

  task automatic test_intensity_tick();
    logic [23:0] d;
    logic [5:0]  p;
    d = rand_bcd();
    p = 6'($urandom);
    digits = d;
    dp_mask = p;
    cap_q.delete();
    ack_cnt = 0;
    @(negedge clk);
    intensity_req = 1'b1;
    intensity_val = 4'h3;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    n_vec++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL cfg_valid got %b want 1", word_valid); end
    n_vec++; if (word_data !== 16'h0A03) begin n_err++; $display("FAIL cfg_word got %h want 0a03", word_data); end
    @(negedge clk);
    n_vec++; if (intensity_ack !== 1'b1) begin n_err++; $display("FAIL cfg_ack_timing got %b want 1", intensity_ack); end
    intensity_req = 1'b0;
    intensity_val = 4'hC;
    wait_words(7, 600, "cfg_frame");
    wait_idle(200, "cfg_frame");
    repeat (60) @(negedge clk);
    n_vec++; if (cap_q.size() != 7) begin n_err++; $display("FAIL cfg_frame_count got %0d want 7", cap_q.size()); end
    n_vec++;
    if (cap_q.size() < 1 || cap_q[0] !== 16'h0A03) begin
      n_err++;
      $display("FAIL cfg_first got %h want 0a03", (cap_q.size() > 0) ? cap_q[0] : 16'hxxxx);
    end
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (i + 1 >= cap_q.size() || cap_q[i+1] !== digit_word(i, d, p)) begin
        n_err++;
        $display("FAIL cfg_frame_word%0d got %h want %h", i, (i + 1 < cap_q.size()) ? cap_q[i+1] : 16'hxxxx, digit_word(i, d, p));
      end
    end
    n_vec++; if (ack_cnt != 1) begin n_err++; $display("FAIL cfg_ack_count got %0d want 1", ack_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [23:0] d;
    logic [5:0]  p;
    int k;
    d = rand_bcd();
    p = 6'($urandom);
    digits = d;
    dp_mask = p;
    cap_q.delete();
    pulse_tick();
    wait_words(3, 400, "mid");
    repeat (5) @(negedge clk);
    pulse_tick();
    k = 0;
    while (!word_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_vec++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL mid_digit3_valid got %b want 1", word_valid); end
    n_vec++; if (word_data !== digit_word(3, d, p)) begin n_err++; $display("FAIL mid_digit3_word got %h want %h", word_data, digit_word(3, d, p)); end
    #2 res = 1'b1;
    #1;
    n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_valid got %b want 0", word_valid); end
    n_vec++; if (word_data !== 16'h0000) begin n_err++; $display("FAIL mid_reset_word got %h want 0000", word_data); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_reset_busy got %b want 1", busy); end
    n_vec++; if (init_done !== 1'b0) begin n_err++; $display("FAIL mid_reset_init_done got %b want 0", init_done); end
    @(negedge clk);
    cap_q.delete();
    #1 res = 1'b0;
    @(negedge clk);
    n_vec++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL reinit_valid got %b want 1", word_valid); end
    n_vec++; if (word_data !== 16'h0C01) begin n_err++; $display("FAIL reinit_first got %h want 0c01", word_data); end
    wait_words(5, 400, "reinit");
    wait_idle(100, "reinit");
    repeat (150) @(negedge clk);
    n_vec++; if (cap_q.size() != 5) begin n_err++; $display("FAIL reinit_count got %0d want 5", cap_q.size()); end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (i >= cap_q.size() || cap_q[i] !== INIT_EXP[i]) begin
        n_err++;
        $display("FAIL reinit_word%0d got %h want %h", i, (i < cap_q.size()) ? cap_q[i] : 16'hxxxx, INIT_EXP[i]);
      end
    end
    n_vec++; if (init_done !== 1'b1) begin n_err++; $display("FAIL reinit_done got %b want 1", init_done); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_frame();
    test_random_frames();
    test_display_off();
    test_overrun();
    test_intensity_tick();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
